reg_file_2r1w: RTL and testbench
================================

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter WIDTH, default 8, data bits per register; legal range 1..32.
REQ-002 Parameter DEPTH, default 4, register count; power of two, legal range 2..256.
REQ-003 Derived localparam AW = clog2(DEPTH), address width.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 _wr_en  in  1  active-low write enable.
REQ-007 wr_addr  in  AW  write address.
REQ-008 wr_data  in  WIDTH  write data.
REQ-009 _rda_en  in  1  active-low output enable, read port A.
REQ-010 rda_addr  in  AW  read port A address.
REQ-011 rda_data  out  WIDTH  read port A data; high-Z when _rda_en=1.
REQ-012 _rdb_en  in  1  active-low output enable, read port B.
REQ-013 rdb_addr  in  AW  read port B address.
REQ-014 rdb_data  out  WIDTH  read port B data; high-Z when _rdb_en=1.
REQ-015 clear_req  in  1  active-high request to zero the whole file.
REQ-016 busy  out  1  high while a clear sweep is in progress.

Function
REQ-017 Write: at rising clk with _wr_en=0, state IDLE, reset=0, reg[wr_addr] SHALL take wr_data; one-cycle write latency.
REQ-018 Read: rda_data/rdb_data SHALL combinationally equal reg[rda_addr]/reg[rdb_addr] when the enable is low; zero-cycle latency from address change.
REQ-019 Both read ports SHALL operate independently; equal addresses on A and B SHALL return identical data.
REQ-020 FSM states: IDLE, CLEARING; encoding is implementation choice.
REQ-021 IDLE -> CLEARING on rising clk with clear_req=1; clear pointer SHALL load 0 on that edge.
REQ-022 In CLEARING, each rising clk SHALL write 0 to reg[ptr] and increment ptr; after writing DEPTH-1 the FSM SHALL return to IDLE; sweep lasts exactly DEPTH cycles.
REQ-023 busy SHALL be 1 exactly in CLEARING (registered, from the edge after clear_req is accepted until the edge that completes the sweep).
REQ-024 External writes (_wr_en=0) during CLEARING SHALL be ignored and lost.
REQ-025 clear_req during CLEARING SHALL be ignored (no restart, no queuing).
REQ-026 clear_req=1 and _wr_en=0 on the same IDLE edge: the write SHALL complete, then the sweep SHALL zero it.
REQ-027 Reads remain enabled during CLEARING and SHALL show the partially cleared contents.
REQ-028 Pointer SHALL wrap from DEPTH-1 to 0 only via IDLE; no out-of-range write.

Reset
REQ-029 reset=1 at rising clk SHALL set reg[i] = i mod 2^WIDTH for every i, FSM to IDLE, ptr to 0, busy to 0.
REQ-030 reset SHALL override a concurrent write and abort any sweep in progress.
REQ-031 Before the first reset, register contents are undefined; the bench SHALL not check them.

Configuration
REQ-032 Macro REG_FILE_2R1W_BYPASS_EN defined: a read port with enable low and address equal to wr_addr SHALL return wr_data combinationally while _wr_en=0 and state IDLE.
REQ-033 Macro undefined: no bypass; read ports SHALL return stored data, new value visible only after the write edge.
REQ-034 Bypass SHALL never forward during CLEARING or while reset=1.

Verification
REQ-035 WIDTH=8, DEPTH=4: reset -> reg[0..3] read as 0,1,2,3 on both ports.
REQ-036 write 0xA5 to addr 2, read A addr 2 and B addr 2 next cycle -> both 0xA5; _rda_en=1 -> rda_data = Z.
REQ-037 clear_req one cycle -> busy high exactly 4 cycles; writes of 0xFF issued during busy ignored; all regs read 0 afterward.
REQ-038 reset asserted on second sweep cycle -> busy 0 next edge, regs 0,1,2,3.
REQ-039 _wr_en=0, wr_addr=1, wr_data=0x3C, rda_addr=1, before edge -> 0x3C with BYPASS_EN, 0x01 without.
REQ-040 WIDTH=4, DEPTH=16: reset -> reg[15] reads 0xF; clear sweep lasts 16 cycles.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write register file with self-timed clear sweep; optional write->read bypass via REG_FILE_2R1W_BYPASS_EN.
// Latency: writes land on the next clk edge, reads are combinational, and a clear takes DEPTH cycles.
// Backpressure: none; busy flags the sweep, during which external writes are dropped.
module reg_file_2r1w #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             _wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             _rda_en,
    input  logic [AW-1:0]    rda_addr,
    output logic [WIDTH-1:0] rda_data,
    input  logic             _rdb_en,
    input  logic [AW-1:0]    rdb_addr,
    output logic [WIDTH-1:0] rdb_data,
    input  logic             clear_req,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        CLEARING
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    ptr, ptr_nxt;
    logic             clr_we;
    logic             wr_do;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rda_val, rdb_val;

    assign wr_do = !_wr_en && (state == IDLE);
    assign busy  = (state == CLEARING);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we    = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEARING;
                    ptr_nxt   = '0;
                end
            end
            CLEARING: begin
                clr_we = 1'b1;
                // Leave the pointer parked at 0 on the last step so it never walks past DEPTH-1.
                if (ptr == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(i);
            end
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (clr_we) begin
                mem[ptr] <= '0;
            end else if (wr_do) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        rda_val = mem[rda_addr];
        rdb_val = mem[rdb_addr];
`ifdef REG_FILE_2R1W_BYPASS_EN
        // Forward only when the same edge would actually commit this write.
        if (wr_do && !reset && (rda_addr == wr_addr)) begin
            rda_val = wr_data;
        end
        if (wr_do && !reset && (rdb_addr == wr_addr)) begin
            rdb_val = wr_data;
        end
`else
`endif
    end

    assign rda_data = _rda_en ? 'z : rda_val;
    assign rdb_data = _rdb_en ? 'z : rdb_val;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench: one 8x4 instance for the main behaviour and one 4x16 instance for width/depth boundaries.
module tb_reg_file_2r1w;

`ifdef REG_FILE_2R1W_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit x 4 instance
    logic       reset, _wr_en, _rda_en, _rdb_en, clear_req;
    logic [1:0] wr_addr, rda_addr, rdb_addr;
    logic [7:0] wr_data;
    wire  [7:0] rda_data, rdb_data;
    wire        busy;

    // 4-bit x 16 instance
    logic       reset_w, _wr_en_w, _rda_en_w, _rdb_en_w, clear_req_w;
    logic [3:0] wr_addr_w, rda_addr_w, rdb_addr_w;
    logic [3:0] wr_data_w;
    wire  [3:0] rda_data_w, rdb_data_w;
    wire        busy_w;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt;

    reg_file_2r1w #(.WIDTH(8), .DEPTH(4)) u_rf8 (
        .clk(clk), .reset(reset), ._wr_en(_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        ._rda_en(_rda_en), .rda_addr(rda_addr), .rda_data(rda_data),
        ._rdb_en(_rdb_en), .rdb_addr(rdb_addr), .rdb_data(rdb_data),
        .clear_req(clear_req), .busy(busy)
    );

    reg_file_2r1w #(.WIDTH(4), .DEPTH(16)) u_rf4 (
        .clk(clk), .reset(reset_w), ._wr_en(_wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
        ._rda_en(_rda_en_w), .rda_addr(rda_addr_w), .rda_data(rda_data_w),
        ._rdb_en(_rdb_en_w), .rdb_addr(rdb_addr_w), .rdb_data(rdb_data_w),
        .clear_req(clear_req_w), .busy(busy_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; _wr_en = 1'b1; wr_addr = '0; wr_data = '0;
        _rda_en = 1'b0; _rdb_en = 1'b0; rda_addr = '0; rdb_addr = '0; clear_req = 1'b0;
        reset_w = 1'b1; _wr_en_w = 1'b1; wr_addr_w = '0; wr_data_w = '0;
        _rda_en_w = 1'b0; _rdb_en_w = 1'b0; rda_addr_w = '0; rdb_addr_w = '0; clear_req_w = 1'b0;

        // Reset image 0,1,2,3 on both ports
        tick();
        reset = 1'b0;
        reset_w = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rda_addr = 2'(i);
            rdb_addr = 2'(i);
            #1;
            chk("rst_rda", 32'(rda_data), 32'(i));
            chk("rst_rdb", 32'(rdb_data), 32'(i));
        end

        // Write 0xA5 to addr 2, read on both ports next cycle
        rda_addr = 2'd1; rdb_addr = 2'd0;
        _wr_en = 1'b0; wr_addr = 2'd2; wr_data = 8'hA5;
        tick();
        _wr_en = 1'b1;
        rda_addr = 2'd2; rdb_addr = 2'd2;
        #1;
        chk("wr_rda", 32'(rda_data), 32'hA5);
        chk("wr_rdb", 32'(rdb_data), 32'hA5);

        // Disabled port must release the bus (two-state simulators resolve Z to 0)
        _rda_en = 1'b1;
        #1;
        n_chk++;
        assert (rda_data === 8'hzz || rda_data === 8'h00)
        else begin
            n_fail++;
            $error("FAIL rda_hiz: observed %h expected zz", rda_data);
        end
        chk("rdb_indep", 32'(rdb_data), 32'hA5);
        _rda_en = 1'b0;

        // Same-cycle read of the address being written
        _wr_en = 1'b0; wr_addr = 2'd1; wr_data = 8'h3C;
        rda_addr = 2'd1; rdb_addr = 2'd0;
        #1;
        chk("bypass_rda", 32'(rda_data), BYP ? 32'h3C : 32'h01);
        chk("bypass_other", 32'(rdb_data), 32'h00);
        tick();
        _wr_en = 1'b1;
        #1;
        chk("post_wr_rda", 32'(rda_data), 32'h3C);

        // Clear sweep: contents 0,3C,A5,03; busy for 4 cycles, 0xFF writes ignored
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("clr_busy_hi", 32'(busy), 32'd1);
            _wr_en = 1'b0; wr_addr = 2'(k); wr_data = 8'hFF;
            clear_req = (k == 1);
            if (k == 2) begin
                // reg0 and reg1 cleared, reg2 not yet; write to addr 2 must not forward
                rda_addr = 2'd1; rdb_addr = 2'd2;
                #1;
                chk("clr_partial_a", 32'(rda_data), 32'h00);
                chk("clr_partial_b", 32'(rdb_data), 32'hA5);
            end
            tick();
        end
        _wr_en = 1'b1; clear_req = 1'b0;
        chk("clr_busy_lo", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rda_addr = 2'(i); rdb_addr = 2'(i);
            #1;
            chk("clr_rda", 32'(rda_data), 32'h00);
            chk("clr_rdb", 32'(rdb_data), 32'h00);
        end
        tick();
        chk("clr_no_restart", 32'(busy), 32'd0);

        // Reset on the second sweep cycle aborts the sweep and beats a write
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        reset = 1'b1; _wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h77;
        tick();
        reset = 1'b0; _wr_en = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rda_addr = 2'(i); rdb_addr = 2'(3 - i);
            #1;
            chk("abort_rda", 32'(rda_data), 32'(i));
            chk("abort_rdb", 32'(rdb_data), 32'(3 - i));
        end
        tick();
        chk("abort_stays_idle", 32'(busy), 32'd0);

        // Write and clear_req on the same edge: write lands, sweep then zeroes it
        _wr_en = 1'b0; wr_addr = 2'd3; wr_data = 8'hEE; clear_req = 1'b1;
        rda_addr = 2'd3;
        tick();
        _wr_en = 1'b1; clear_req = 1'b0;
        chk("wrclr_busy", 32'(busy), 32'd1);
        chk("wrclr_landed", 32'(rda_data), 32'hEE);
        for (int k = 0; k < 4; k++) tick();
        chk("wrclr_done", 32'(busy), 32'd0);
        chk("wrclr_zeroed", 32'(rda_data), 32'h00);

        // WIDTH=4, DEPTH=16 instance
        rda_addr_w = 4'd15; rdb_addr_w = 4'd5;
        #1;
        chk("w16_rst_15", 32'(rda_data_w), 32'hF);
        chk("w16_rst_5", 32'(rdb_data_w), 32'h5);
        clear_req_w = 1'b1;
        tick();
        clear_req_w = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40 && busy_w; k++) begin
            cnt++;
            tick();
        end
        chk("w16_sweep_len", 32'(cnt), 32'd16);
        chk("w16_clr_15", 32'(rda_data_w), 32'h0);
        chk("w16_clr_5", 32'(rdb_data_w), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
